// File: rtl/kernel_cc_wb_pkg.sv
// Shared definitions for the CC-kernel write_back controller.
//   wb_state_e      : controller state encoding
//   bytes_per_word  : byte stride between consecutive label writes
package kernel_cc_wb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } wb_state_e;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  // Address stride of one label word.
  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/kernel_cc_wb_outstanding_cnt.sv
// Saturating up/down count of writes accepted but not yet responded.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   inc_i          : request accepted this cycle
//   dec_i          : response returned this cycle (ignored at zero)
//   pending_i      : request currently presented (counts against the limit)
//   zero_next_o    : count will be zero after this edge
//   below_limit_o  : count + pending_i < MAX_COUNT
module kernel_cc_wb_outstanding_cnt #(
  parameter int unsigned MAX_COUNT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic dec_i,
  input  logic pending_i,
  output logic zero_next_o,
  output logic below_limit_o
);

  localparam int unsigned CW  = $clog2(MAX_COUNT + 1);
  localparam int unsigned CW1 = CW + 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Simultaneous inc/dec cancel; never wraps in either direction.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && (count_q != CW'(MAX_COUNT))) begin
      count_d = count_q + CW'(1);
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_next_o   = (count_d == '0);
  assign below_limit_o = ((CW1'(count_q) + CW1'(pending_i)) < CW1'(MAX_COUNT));

endmodule

// File: rtl/kernel_cc_write_back_ctrl.sv
// write_back process of the CC kernel: each start token launches one pass that
// pops num_items labels and writes them to consecutive words from base_addr,
// then pulses done once every write response has returned.
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   start_empty_n/start_read     : start-token FIFO (start_read combinational)
//   num_items, base_addr         : pass parameters, sampled on token pop
//   in_empty_n/in_read/in_dout   : label FIFO, first-word fall-through
//   wr_req_*                     : write request channel (valid/ready)
//   wr_resp_valid/wr_resp_ready  : write responses (always accepted)
//   done                         : one-cycle pass-complete pulse
//   idle                         : controller in IDLE
module kernel_cc_write_back_ctrl
  import kernel_cc_wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned CNT_WIDTH       = 32,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_empty_n,
  output logic                  start_read,
  input  logic [CNT_WIDTH-1:0]  num_items,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_empty_n,
  output logic                  in_read,
  input  logic [DATA_WIDTH-1:0] in_dout,
  output logic                  wr_req_valid,
  input  logic                  wr_req_ready,
  output logic [ADDR_WIDTH-1:0] wr_req_addr,
  output logic [DATA_WIDTH-1:0] wr_req_data,
  input  logic                  wr_resp_valid,
  output logic                  wr_resp_ready,
  output logic                  done,
  output logic                  idle
);

  localparam int unsigned BPW = bytes_per_word(DATA_WIDTH);

  wb_state_e             state_q;
  logic [CNT_WIDTH-1:0]  n_q;
  logic [CNT_WIDTH-1:0]  issued_q;
  logic [ADDR_WIDTH-1:0] addr_next_q;
  logic                  req_valid_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [DATA_WIDTH-1:0] req_data_q;
  logic                  done_q;

  logic slot_free_c;
  logic below_limit_c;
  logic zero_next_c;
  logic load_c;

  // Slot can take a new word if empty or being accepted this cycle.
  assign slot_free_c = !req_valid_q || wr_req_ready;
  assign load_c      = !reset && (state_q == S_RUN) && (issued_q < n_q) &&
                       in_empty_n && slot_free_c && below_limit_c;

  assign start_read    = !reset && (state_q == S_IDLE) && start_empty_n;
  assign in_read       = load_c;
  assign wr_req_valid  = req_valid_q;
  assign wr_req_addr   = req_addr_q;
  assign wr_req_data   = req_data_q;
  assign wr_resp_ready = 1'b1;
  assign done          = done_q;
  assign idle          = (state_q == S_IDLE);

  kernel_cc_wb_outstanding_cnt #(
    .MAX_COUNT (MAX_OUTSTANDING)
  ) u_outstanding (
    .clk           (clk),
    .reset         (reset),
    .inc_i         (req_valid_q && wr_req_ready),
    .dec_i         (wr_resp_valid),
    .pending_i     (req_valid_q),
    .zero_next_o   (zero_next_c),
    .below_limit_o (below_limit_c)
  );

  // Pass sequencing and the single-entry request slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      issued_q    <= '0;
      addr_next_q <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (slot_free_c) begin
        req_valid_q <= 1'b0;
      end
      // Running address wraps naturally modulo 2^ADDR_WIDTH.
      if (load_c) begin
        req_valid_q <= 1'b1;
        req_addr_q  <= addr_next_q;
        req_data_q  <= in_dout;
        addr_next_q <= addr_next_q + ADDR_WIDTH'(BPW);
        issued_q    <= issued_q + CNT_WIDTH'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (start_empty_n) begin
            n_q         <= num_items;
            addr_next_q <= base_addr;
            issued_q    <= '0;
            state_q     <= (num_items != '0) ? S_RUN : S_DRAIN;
          end
        end
        S_RUN: begin
          if ((issued_q == n_q) && slot_free_c) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (zero_next_c) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_cc_write_back_ctrl.sv
// Self-checking bench for kernel_cc_write_back_ctrl (MAX_OUTSTANDING=2).
module tb_kernel_cc_write_back_ctrl;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 32;
  localparam int unsigned CW   = 32;
  localparam int unsigned MAXO = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_empty_n;
  logic          start_read;
  logic [CW-1:0] num_items;
  logic [AW-1:0] base_addr;
  logic          in_empty_n;
  logic          in_read;
  logic [DW-1:0] in_dout;
  logic          wr_req_valid;
  logic          wr_req_ready;
  logic [AW-1:0] wr_req_addr;
  logic [DW-1:0] wr_req_data;
  logic          wr_resp_valid;
  logic          wr_resp_ready;
  logic          done;
  logic          idle;

  always #5 clk = ~clk;

  kernel_cc_write_back_ctrl #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .CNT_WIDTH       (CW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_empty_n (start_empty_n),
    .start_read    (start_read),
    .num_items     (num_items),
    .base_addr     (base_addr),
    .in_empty_n    (in_empty_n),
    .in_read       (in_read),
    .in_dout       (in_dout),
    .wr_req_valid  (wr_req_valid),
    .wr_req_ready  (wr_req_ready),
    .wr_req_addr   (wr_req_addr),
    .wr_req_data   (wr_req_data),
    .wr_resp_valid (wr_resp_valid),
    .wr_resp_ready (wr_resp_ready),
    .done          (done),
    .idle          (idle)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [DW-1:0] lbl_q[$];
  wr_t           exp_q[$];
  int            resp_q[$];

  int resp_budget = 1000;
  int resp_delay  = 2;
  int block_after = 0;
  int block_left  = 0;
  bit starve      = 1'b0;

  int acc_cnt   = 0;
  int rd_cnt    = 0;
  int done_cnt  = 0;
  int valid_cnt = 0;
  int stall_cnt = 0;
  int tok_cyc   = 0;
  int done_cyc  = 0;

  logic          prev_hold = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  // One clock: observe at negedge, update the environment just after posedge.
  task automatic tick();
    bit  pop_lbl;
    bit  pop_tok;
    bit  acc;
    wr_t e;
    @(negedge clk);
    cyc++;
    pop_lbl = (in_read === 1'b1);
    pop_tok = (start_read === 1'b1);
    acc     = (wr_req_valid === 1'b1) && (wr_req_ready === 1'b1);
    if (pop_lbl) begin
      rd_cnt++;
      checks++;
      if (in_empty_n !== 1'b1) begin
        errors++;
        $display("FAIL in_read_when_empty: in_empty_n=%b required 1 (cycle %0d)", in_empty_n, cyc);
      end
      checks++;
      if ((wr_req_valid === 1'b1) && (wr_req_ready !== 1'b1)) begin
        errors++;
        $display("FAIL in_read_while_blocked: in_read=1 with slot stalled, required 0 (cycle %0d)", cyc);
      end
    end
    if (pop_tok) tok_cyc = cyc;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      checks++;
      if (resp_q.size() != 0) begin
        errors++;
        $display("FAIL done_early: %0d responses still pending, required 0", resp_q.size());
      end
    end
    if (wr_req_valid === 1'b1) valid_cnt++;
    if ((wr_req_valid === 1'b1) && (wr_req_ready !== 1'b1)) stall_cnt++;
    if (prev_hold) begin
      checks++;
      if ((wr_req_valid !== 1'b1) || (wr_req_addr !== prev_addr) || (wr_req_data !== prev_data)) begin
        errors++;
        $display("FAIL req_hold: valid=%b addr=%h data=%h required valid=1 addr=%h data=%h",
                 wr_req_valid, wr_req_addr, wr_req_data, prev_addr, prev_data);
      end
    end
    prev_hold = (wr_req_valid === 1'b1) && (wr_req_ready !== 1'b1) && (reset !== 1'b1);
    prev_addr = wr_req_addr;
    prev_data = wr_req_data;
    if (acc) begin
      acc_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%h data=%h required no write", wr_req_addr, wr_req_data);
      end else begin
        e = exp_q.pop_front();
        if ((wr_req_addr !== e.addr) || (wr_req_data !== e.data)) begin
          errors++;
          $display("FAIL wr_payload: addr=%h data=%h required addr=%h data=%h",
                   wr_req_addr, wr_req_data, e.addr, e.data);
        end
      end
      resp_q.push_back(cyc + resp_delay);
    end
    @(posedge clk);
    #1;
    if (pop_lbl && (lbl_q.size() > 0)) lbl_q.delete(0);
    if (pop_tok) start_empty_n = 1'b0;
    wr_resp_valid = 1'b0;
    if ((resp_q.size() > 0) && (resp_q[0] <= cyc) && (resp_budget > 0)) begin
      resp_q.delete(0);
      resp_budget--;
      wr_resp_valid = 1'b1;
    end
    in_empty_n = (lbl_q.size() > 0) && !(starve && ((cyc % 4 == 1) || (cyc % 4 == 2)));
    in_dout    = (lbl_q.size() > 0) ? lbl_q[0] : '0;
    if ((block_left > 0) && (acc_cnt >= block_after)) begin
      wr_req_ready = 1'b0;
      block_left--;
    end else begin
      wr_req_ready = 1'b1;
    end
  endtask

  // Queue labels + expected writes and present a start token.
  task automatic start_pass(input int n, input logic [AW-1:0] base, input int nlabels,
                            input logic [DW-1:0] first);
    wr_t e;
    for (int i = 0; i < nlabels; i++) begin
      lbl_q.push_back(first + DW'(i));
      if (i < n) begin
        e.addr = base + AW'(i * 4);
        e.data = first + DW'(i);
        exp_q.push_back(e);
      end
    end
    num_items     = CW'(n);
    base_addr     = base;
    start_empty_n = 1'b1;
    in_empty_n    = (lbl_q.size() > 0);
    in_dout       = (lbl_q.size() > 0) ? lbl_q[0] : '0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (done_cnt > d0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    start_empty_n = 1'b1;
    tick();
    tick();
    checks++;
    if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b required 1", idle); end
    checks++;
    if (wr_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", wr_req_valid); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++;
    if (start_read !== 1'b0) begin errors++; $display("FAIL reset_start_read: got %b required 0", start_read); end
    checks++;
    if (in_read !== 1'b0) begin errors++; $display("FAIL reset_in_read: got %b required 0", in_read); end
    checks++;
    if (wr_resp_ready !== 1'b1) begin errors++; $display("FAIL resp_ready: got %b required 1", wr_resp_ready); end
    start_empty_n = 1'b0;
    reset         = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    int a0, d0, r0;
    a0 = acc_cnt; d0 = done_cnt; r0 = rd_cnt;
    resp_budget = 1000;
    start_pass(4, 32'h1000, 4, 32'd7);
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: done not seen, required within 200 cycles"); end
    repeat (3) tick();
    checks++;
    if (acc_cnt - a0 != 4) begin errors++; $display("FAIL basic_writes: got %0d required 4", acc_cnt - a0); end
    checks++;
    if (rd_cnt - r0 != 4) begin errors++; $display("FAIL basic_reads: got %0d required 4", rd_cnt - r0); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d required 1", done_cnt - d0); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing: got %0d left required 0", exp_q.size()); end
    checks++;
    if (idle !== 1'b1) begin errors++; $display("FAIL basic_idle: got %b required 1", idle); end
  endtask

  task automatic test_zero_items();
    bit ok;
    int r0, v0;
    r0 = rd_cnt; v0 = valid_cnt;
    start_pass(0, 32'h7000, 1, 32'h55);
    wait_done(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_timeout: done not seen, required within 50 cycles"); end
    checks++;
    if (done_cyc - tok_cyc != 2) begin errors++; $display("FAIL zero_latency: got %0d required 2", done_cyc - tok_cyc); end
    checks++;
    if (rd_cnt != r0) begin errors++; $display("FAIL zero_in_read: got %0d required 0", rd_cnt - r0); end
    checks++;
    if (valid_cnt != v0) begin errors++; $display("FAIL zero_req_valid: got %0d required 0", valid_cnt - v0); end
    checks++;
    if (lbl_q.size() != 1) begin errors++; $display("FAIL zero_label_kept: got %0d required 1", lbl_q.size()); end
    lbl_q.delete();
    in_empty_n = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    int a0, s0;
    a0 = acc_cnt; s0 = stall_cnt;
    block_after = acc_cnt + 1;
    block_left  = 5;
    start_pass(3, 32'h2000, 3, 32'd100);
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout: done not seen, required within 200 cycles"); end
    checks++;
    if (stall_cnt - s0 != 5) begin errors++; $display("FAIL bp_stall_cycles: got %0d required 5", stall_cnt - s0); end
    checks++;
    if (acc_cnt - a0 != 3) begin errors++; $display("FAIL bp_writes: got %0d required 3", acc_cnt - a0); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_missing: got %0d left required 0", exp_q.size()); end
    tick();
  endtask

  task automatic test_outstanding_cap();
    bit ok;
    int a0;
    a0 = acc_cnt;
    resp_budget = 0;
    start_pass(6, 32'h3000, 6, 32'd200);
    repeat (20) tick();
    checks++;
    if (acc_cnt - a0 != 2) begin errors++; $display("FAIL cap_hold: got %0d accepted required 2", acc_cnt - a0); end
    checks++;
    if (wr_req_valid !== 1'b0) begin errors++; $display("FAIL cap_valid: got %b required 0", wr_req_valid); end
    resp_budget = 1;
    repeat (15) tick();
    checks++;
    if (acc_cnt - a0 != 3) begin errors++; $display("FAIL cap_release_one: got %0d accepted required 3", acc_cnt - a0); end
    resp_budget = 1000;
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL cap_timeout: done not seen, required within 200 cycles"); end
    checks++;
    if (acc_cnt - a0 != 6) begin errors++; $display("FAIL cap_writes: got %0d required 6", acc_cnt - a0); end
    tick();
  endtask

  task automatic test_starved();
    bit ok;
    int a0, r0;
    a0 = acc_cnt; r0 = rd_cnt;
    starve = 1'b1;
    start_pass(4, 32'h4000, 5, 32'd300);
    wait_done(200, ok);
    starve = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL starve_timeout: done not seen, required within 200 cycles"); end
    checks++;
    if (rd_cnt - r0 != 4) begin errors++; $display("FAIL starve_reads: got %0d required 4", rd_cnt - r0); end
    checks++;
    if (acc_cnt - a0 != 4) begin errors++; $display("FAIL starve_writes: got %0d required 4", acc_cnt - a0); end
    checks++;
    if (lbl_q.size() != 1) begin errors++; $display("FAIL starve_leftover: got %0d required 1", lbl_q.size()); end
    lbl_q.delete();
    in_empty_n = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int a0, d0;
    a0 = acc_cnt;
    resp_budget = 0;
    start_pass(5, 32'h5000, 5, 32'd400);
    for (int i = 0; i < 50 && (acc_cnt - a0) < 2; i++) tick();
    checks++;
    if (acc_cnt - a0 != 2) begin errors++; $display("FAIL rst_setup: got %0d accepted required 2", acc_cnt - a0); end
    tick();
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (idle !== 1'b1) begin errors++; $display("FAIL rst_mid_idle: got %b required 1", idle); end
    checks++;
    if (wr_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b required 0", wr_req_valid); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b required 0", done); end
    lbl_q.delete();
    exp_q.delete();
    in_empty_n  = 1'b0;
    resp_budget = 1000;
    repeat (8) tick();
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL rst_late_resp_done: got %0d pulses required 0", done_cnt - d0); end
    a0 = acc_cnt;
    start_pass(2, 32'h6000, 2, 32'd500);
    wait_done(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_new_pass_timeout: done not seen, required within 100 cycles"); end
    checks++;
    if (acc_cnt - a0 != 2) begin errors++; $display("FAIL rst_new_pass_writes: got %0d required 2", acc_cnt - a0); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rst_new_pass_missing: got %0d left required 0", exp_q.size()); end
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    start_empty_n = 1'b0;
    num_items     = '0;
    base_addr     = '0;
    in_empty_n    = 1'b0;
    in_dout       = '0;
    wr_req_ready  = 1'b1;
    wr_resp_valid = 1'b0;
    test_reset();
    test_basic();
    test_zero_items();
    test_backpressure();
    test_outstanding_cap();
    test_starved();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
